// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences single ops and shift-add multiplies through an external Hack ALU
module alu_seq_ctrl #(
   parameter int         WIDTH    = 16,
   parameter logic [5:0] OP_ADD   = 6'b000010,
   parameter logic [5:0] OP_PASSX = 6'b001100,
   parameter logic [5:0] OP_ZERO  = 6'b101010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_cmd,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [5:0]       req_opr,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zr,
   output logic             rsp_ng,
   output logic             busy,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [5:0]       alu_opr,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zr,
   input  logic             alu_ng
);
   localparam logic [2:0] S_IDLE = 3'd0, S_EXEC = 3'd1, S_MUL = 3'd2, S_MFIN = 3'd3, S_DONE = 3'd4;
   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, mp_q, mp_d, data_q, data_d;
   logic [5:0]       opr_q, opr_d;
   logic             zr_q, zr_d, ng_q, ng_d;
   assign busy      = state_q != S_IDLE;
   assign req_ready = state_q == S_IDLE && !rst;
   assign rsp_valid = state_q == S_DONE;
   assign rsp_data  = data_q;
   assign rsp_zr    = zr_q;
   assign rsp_ng    = ng_q;
   // ALU operand/control drive; mc/mp double as the single-op x/y latches
   always_comb begin
      alu_x   = '0;
      alu_y   = '0;
      alu_opr = OP_ZERO;
      case (state_q)
         S_EXEC: begin
            alu_x   = mc_q;
            alu_y   = mp_q;
            alu_opr = opr_q;
         end
         S_MUL: if (mp_q != '0) begin
            alu_x   = mp_q[0] ? acc_q : mc_q;
            alu_y   = mc_q;
            alu_opr = OP_ADD;
         end
         S_MFIN: begin
            alu_x   = acc_q;
            alu_opr = OP_PASSX;
         end
         default: ;
      endcase
   end
   // Next state: add clears the multiplier lsb, otherwise the multiplicand doubles and the multiplier shifts
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mc_d    = mc_q;
      mp_d    = mp_q;
      opr_d   = opr_q;
      data_d  = data_q;
      zr_d    = zr_q;
      ng_d    = ng_q;
      case (state_q)
         S_IDLE: if (req_valid && req_ready) begin
            acc_d   = '0;
            mc_d    = req_a;
            mp_d    = req_b;
            opr_d   = req_opr;
            state_d = req_cmd ? S_MUL : S_EXEC;
         end
         S_EXEC, S_MFIN: begin
            data_d  = alu_out;
            zr_d    = alu_zr;
            ng_d    = alu_ng;
            state_d = S_DONE;
         end
         S_MUL: if (mp_q == '0) state_d = S_MFIN;
         else if (mp_q[0]) begin
            acc_d = alu_out;
            mp_d  = {mp_q[WIDTH-1:1], 1'b0};
         end else begin
            mc_d = alu_out;
            mp_d = mp_q >> 1;
         end
         S_DONE: if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         mc_q    <= '0;
         mp_q    <= '0;
         opr_q   <= '0;
         data_q  <= '0;
         zr_q    <= 1'b0;
         ng_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mc_q    <= mc_d;
         mp_q    <= mp_d;
         opr_q   <= opr_d;
         data_q  <= data_d;
         zr_q    <= zr_d;
         ng_q    <= ng_d;
      end
   end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: vector table plus handshake corner cases against a behavioural Hack ALU
module tb_alu_seq_ctrl;
   localparam logic [5:0] OP_ADD = 6'b000010, OP_ZERO = 6'b101010;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid, req_ready, req_cmd, rsp_valid, rsp_ready, rsp_zr, rsp_ng, busy, alu_zr, alu_ng;
   logic [15:0] req_a, req_b, rsp_data, alu_x, alu_y, alu_out;
   logic [5:0]  req_opr, alu_opr;
   logic [15:0] x0, x1, y0, y1, s0, s1;
   typedef struct {
      logic        cmd;
      logic [15:0] a, b;
      logic [5:0]  opr;
      logic [15:0] d;
      int          lat;
      int          adds;
   } vec_t;
   typedef struct {
      logic [15:0] d;
      logic        zr, ng;
      int          cyc;
   } exp_t;
   vec_t vt[12];
   exp_t exp_q[$];
   exp_t cur;
   int   n_vec = 0, n_bad = 0, cyc = 0, add_cnt = 0;
   logic seen = 1'b0;

   alu_seq_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_a(req_a), .req_b(req_b), .req_opr(req_opr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .busy(busy), .alu_x(alu_x), .alu_y(alu_y),
      .alu_opr(alu_opr), .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Hack ALU: control bits {zx,nx,zy,ny,f,no}
   always_comb begin
      x0 = alu_opr[5] ? 16'h0 : alu_x;
      x1 = alu_opr[4] ? ~x0 : x0;
      y0 = alu_opr[3] ? 16'h0 : alu_y;
      y1 = alu_opr[2] ? ~y0 : y0;
      s0 = alu_opr[1] ? x1 + y1 : x1 & y1;
      s1 = alu_opr[0] ? ~s0 : s0;
   end
   assign alu_out = s1;
   assign alu_zr  = s1 == 16'h0;
   assign alu_ng  = s1[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic expect_rsp(input logic [15:0] d, input int at);
      exp_t e;
      e.d   = d;
      e.zr  = d == 16'h0;
      e.ng  = d[15];
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   // Scoreboard: pop on the first cycle of each response, then require it to hold
   always @(negedge clk) begin
      if (alu_opr == OP_ADD) add_cnt++;
      if (rst || !rsp_valid) seen = 1'b0;
      else if (!seen) begin
         seen = 1'b1;
         chk("rsp expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("rsp_data", rsp_data, cur.d);
            chk("rsp_zr", rsp_zr, cur.zr);
            chk("rsp_ng", rsp_ng, cur.ng);
            chk("latency", cyc, cur.cyc);
         end
      end else chk("rsp hold", rsp_data, cur.d);
   end

   task automatic send(input logic cmd, input logic [15:0] a, input logic [15:0] b,
                       input logic [5:0] op, input logic [15:0] d, input int lat);
      int t = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_cmd   = cmd;
      req_a     = a;
      req_b     = b;
      req_opr   = op;
      while (!req_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("accept", req_ready, 1);
      add_cnt = 0;
      expect_rsp(d, cyc + 1 + lat);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!rsp_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("rsp_valid", rsp_valid, 1);
   endtask

   task automatic finish_rsp(input int adds);
      wait_valid();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp drop", rsp_valid, 0);
      if (adds >= 0) chk("add cycles", add_cnt, adds);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{1'b0, 16'd112,  16'd310,  6'b000010, 16'd422,  1,  -1};
      vt[1]  = '{1'b0, 16'd112,  16'd310,  6'b010011, 16'hFF3A, 1,  -1};
      vt[2]  = '{1'b0, 16'd112,  16'd310,  6'b000000, 16'h0030, 1,  -1};
      vt[3]  = '{1'b0, 16'd112,  16'd310,  6'b001101, 16'hFF8F, 1,  -1};
      vt[4]  = '{1'b0, 16'd112,  16'd310,  6'b101010, 16'h0000, 1,  -1};
      vt[5]  = '{1'b1, 16'd112,  16'd310,  6'b000000, 16'h87A0, 15, 13};
      vt[6]  = '{1'b1, 16'hFF90, 16'd310,  6'b111111, 16'h7860, 15, -1};
      vt[7]  = '{1'b1, 16'd112,  16'hFECA, 6'b000000, 16'h7860, 28, -1};
      vt[8]  = '{1'b1, 16'd112,  16'h0000, 6'b000000, 16'h0000, 2,  -1};
      vt[9]  = '{1'b1, 16'h0000, 16'hFFFF, 6'b000000, 16'h0000, 33, -1};
      vt[10] = '{1'b1, 16'hFFFF, 16'hFFFF, 6'b000000, 16'h0001, 33, -1};
      vt[11] = '{1'b1, 16'd3,    16'd5,    6'b000000, 16'h000F, 6,  -1};
      req_valid = 1'b0;
      req_cmd   = 1'b0;
      req_a     = 16'h0;
      req_b     = 16'h0;
      req_opr   = 6'h0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_data", rsp_data, 0);
      chk("reset rsp_zr", rsp_zr, 0);
      chk("reset rsp_ng", rsp_ng, 0);
      chk("reset req_ready", req_ready, 0);
      chk("reset alu_opr", alu_opr, OP_ZERO);
      chk("reset alu_x", alu_x, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle req_ready", req_ready, 1);
      foreach (vt[i]) begin
         send(vt[i].cmd, vt[i].a, vt[i].b, vt[i].opr, vt[i].d, vt[i].lat);
         finish_rsp(vt[i].adds);
      end
      // backpressure with a competing request held at the port
      rsp_ready = 1'b0;
      send(1'b1, 16'd3, 16'd5, 6'b000000, 16'h000F, 6);
      wait_valid();
      req_valid = 1'b1;
      req_cmd   = 1'b0;
      req_a     = 16'd7;
      req_b     = 16'd5;
      req_opr   = OP_ADD;
      repeat (5) begin
         @(negedge clk);
         chk("bp rsp_valid", rsp_valid, 1);
         chk("bp rsp_data", rsp_data, 16'h000F);
         chk("bp req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp drop", rsp_valid, 0);
      chk("bp reopen", req_ready, 1);
      expect_rsp(16'd12, cyc + 2);
      @(negedge clk);
      req_valid = 1'b0;
      finish_rsp(-1);
      // reset in the middle of a multiply
      send(1'b1, 16'd112, 16'd310, 6'b000000, 16'h87A0, 15);
      repeat (5) @(negedge clk);
      chk("pre-reset busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid-reset busy", busy, 0);
      chk("mid-reset rsp_valid", rsp_valid, 0);
      chk("mid-reset alu_opr", alu_opr, OP_ZERO);
      chk("mid-reset req_ready", req_ready, 0);
      chk("mid-reset rsp_data", rsp_data, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      send(1'b0, 16'd5, 16'd7, OP_ADD, 16'd12, 1);
      finish_rsp(-1);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
